// File: rtl/aes_round_sequencer.sv
// Iterative AES round sequencer: drives an external single-round datapath through Nr+1 rounds
// per direction and holds the cipher state between rounds. Optional macro: AES_SEQ_PERF_EN.
module aes_round_sequencer #(
  parameter int DW     = 128,
  parameter int NR_128 = 10,
  parameter int NR_192 = 12,
  parameter int NR_256 = 14,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        ksel,
  input  logic [1:0]        op,
  input  logic [DW-1:0]     din,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     dout,
  output logic              pass,
  output logic              err,
  output logic              rnd_req,
  input  logic              rnd_ack,
  output logic              rnd_dec,
  output logic [RIDX_W-1:0] rnd_idx,
  output logic              rnd_first,
  output logic              rnd_last,
  output logic [DW-1:0]     rnd_st,
  input  logic [DW-1:0]     rnd_res
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DEC  = 2'd2,
    FIN  = 2'd3
  } fsm_t;

  localparam logic [1:0] OP_ENC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_RT  = 2'b10;

  fsm_t              fsm_r, fsm_next_s;
  logic [RIDX_W-1:0] r_r, r_next_s;
  logic [RIDX_W-1:0] nr_r, nr_next_s;
  logic [1:0]        op_r;
  logic [DW-1:0]     st_r, orig_r;
  logic              accept_s, illegal_s, round_ack_s;

  logic              req_next_s, dec_next_s, first_next_s, last_next_s;
  logic              busy_next_s, done_next_s, pass_next_s, err_next_s;
  logic [RIDX_W-1:0] idx_next_s;
  logic [DW-1:0]     dout_next_s;

  function automatic logic [RIDX_W-1:0] nr_of(input logic [1:0] k);
    logic [RIDX_W-1:0] n;
    case (k)
      2'b00:   n = RIDX_W'(NR_128);
      2'b01:   n = RIDX_W'(NR_192);
      2'b10:   n = RIDX_W'(NR_256);
      default: n = RIDX_W'(NR_128);
    endcase
    return n;
  endfunction

  assign round_ack_s = rnd_ack && ((fsm_r == ENC) || (fsm_r == DEC));
  assign rnd_st      = st_r;

  // FSM state, round counter and latched round count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r <= IDLE;
      r_r   <= '0;
      nr_r  <= '0;
    end else begin
      fsm_r <= fsm_next_s;
      r_r   <= r_next_s;
      nr_r  <= nr_next_s;
    end
  end

  // Next-state logic; a missing ack simply leaves everything where it is
  always_comb begin
    fsm_next_s = fsm_r;
    r_next_s   = r_r;
    nr_next_s  = nr_r;
    accept_s   = 1'b0;
    illegal_s  = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (start) begin
          if ((ksel == 2'b11) || (op == 2'b11)) begin
            illegal_s = 1'b1;
          end else begin
            accept_s   = 1'b1;
            nr_next_s  = nr_of(ksel);
            r_next_s   = '0;
            fsm_next_s = (op == OP_DEC) ? DEC : ENC;
          end
        end else begin
          fsm_next_s = IDLE;
        end
      end
      ENC, DEC: begin
        if (rnd_ack) begin
          if (r_r < nr_r) begin
            r_next_s = r_r + RIDX_W'(1);
          end else begin
            r_next_s   = '0;
            fsm_next_s = ((fsm_r == ENC) && (op_r == OP_RT)) ? DEC : FIN;
          end
        end else begin
          r_next_s = r_r;
        end
      end
      FIN:     fsm_next_s = IDLE;
      default: fsm_next_s = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state so outputs stay registered
  always_comb begin
    req_next_s   = (fsm_next_s == ENC) || (fsm_next_s == DEC);
    dec_next_s   = (fsm_next_s == DEC);
    first_next_s = req_next_s && (r_next_s == '0);
    last_next_s  = req_next_s && (r_next_s == nr_next_s);
    busy_next_s  = (fsm_next_s != IDLE);
    done_next_s  = (fsm_r == FIN);
    err_next_s   = illegal_s;
    case (fsm_next_s)
      ENC:     idx_next_s = r_next_s;
      DEC:     idx_next_s = nr_next_s - r_next_s;
      default: idx_next_s = '0;
    endcase
    if (fsm_r == FIN) begin
      dout_next_s = st_r;
      pass_next_s = (op_r == OP_RT) && (st_r == orig_r);
    end else begin
      dout_next_s = dout;
      pass_next_s = pass;
    end
  end

  // Cipher state, original block and latched operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r   <= '0;
      orig_r <= '0;
      op_r   <= OP_ENC;
    end else if (accept_s) begin
      st_r   <= din;
      orig_r <= din;
      op_r   <= op;
    end else if (round_ack_s) begin
      st_r <= rnd_res;
    end
  end

  // Registered handshake and datapath-control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= 1'b0;
      dout      <= '0;
      rnd_req   <= 1'b0;
      rnd_dec   <= 1'b0;
      rnd_idx   <= '0;
      rnd_first <= 1'b0;
      rnd_last  <= 1'b0;
    end else begin
      busy      <= busy_next_s;
      done      <= done_next_s;
      pass      <= pass_next_s;
      err       <= err_next_s;
      dout      <= dout_next_s;
      rnd_req   <= req_next_s;
      rnd_dec   <= dec_next_s;
      rnd_idx   <= idx_next_s;
      rnd_first <= first_next_s;
      rnd_last  <= last_next_s;
    end
  end

`ifdef AES_SEQ_PERF_EN
  logic [15:0] perf_cnt_r;

  // Cycle counter starts at 1 on the accept edge so the value latched at done equals the latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_r  <= 16'd0;
      perf_cycles <= 16'd0;
    end else begin
      if (accept_s) begin
        perf_cnt_r <= 16'd1;
      end else if (((fsm_r == ENC) || (fsm_r == DEC)) && (perf_cnt_r != 16'hFFFF)) begin
        perf_cnt_r <= perf_cnt_r + 16'd1;
      end
      if (fsm_r == FIN) begin
        perf_cycles <= perf_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer with an invertible toy round datapath
// (rotate + per-index round key) and a sequence-level reference model.
module tb_aes_round_sequencer;

  typedef struct {
    logic [1:0]   ksel;
    logic [1:0]   op;
    logic [127:0] din;
    int           stall_idx;
    int           stall_len;
    bit           corrupt;
    bit           poke;
    int           exp_lat;
    bit           exp_pass;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, start, rnd_ack;
  logic [1:0]   ksel, op;
  logic [127:0] din, dout, rnd_st, rnd_res;
  logic         busy, done, pass, err, rnd_req, rnd_dec, rnd_first, rnd_last;
  logic [3:0]   rnd_idx;
  bit           corrupt;
`ifdef AES_SEQ_PERF_EN
  logic [15:0]  perf_cycles;
`endif

  int total = 0;
  int bad   = 0;
  vec_t tab[6];

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ksel(ksel), .op(op), .din(din),
    .busy(busy), .done(done), .dout(dout), .pass(pass), .err(err),
    .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd_dec(rnd_dec), .rnd_idx(rnd_idx),
    .rnd_first(rnd_first), .rnd_last(rnd_last), .rnd_st(rnd_st), .rnd_res(rnd_res)
`ifdef AES_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  function automatic logic [127:0] rk(input logic [3:0] i);
    logic [31:0] w;
    w = (32'h9E3779B9 * {28'd0, i}) ^ 32'h7F4A7C15;
    return {w, w ^ 32'h01234567, ~w, w + 32'h00001111};
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] s, input logic [3:0] i);
    return {s[120:0], s[127:121]} ^ rk(i);
  endfunction

  function automatic logic [127:0] inv(input logic [127:0] s, input logic [3:0] i);
    logic [127:0] t;
    t = s ^ rk(i);
    return {t[6:0], t[127:7]};
  endfunction

  // Toy datapath; when corrupt is set, bit 0 is flipped on the last inverse round
  assign rnd_res = rnd_dec ? (inv(rnd_st, rnd_idx) ^ ((corrupt && rnd_last) ? 128'd1 : 128'd0))
                           : fwd(rnd_st, rnd_idx);

  function automatic int nr_of(input logic [1:0] k);
    return (k == 2'd0) ? 10 : (k == 2'd1) ? 12 : 14;
  endfunction

  // Reference: returns {pass, dout} for a full operation
  function automatic logic [128:0] model(input vec_t v);
    logic [127:0] s;
    int nr;
    nr = nr_of(v.ksel);
    s  = v.din;
    if (v.op != 2'd1) for (int i = 0; i <= nr; i++) s = fwd(s, 4'(i));
    if (v.op != 2'd0) begin
      for (int i = nr; i >= 0; i--) begin
        s = inv(s, 4'(i));
        if (v.corrupt && i == 0) s = s ^ 128'd1;
      end
    end
    return {(v.op == 2'd2) && (s == v.din), s};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic run_op(input vec_t v, input bit rnd_stall);
    logic [128:0] m;
    logic [6:0]   expq[$];
    logic [6:0]   gotq[$];
    logic [3:0]   h_idx;
    logic [127:0] h_st;
    int nr, n, rstalls, stall_left, mism;
    bit hold_chk, got_done;
    m  = model(v);
    nr = nr_of(v.ksel);
    if (v.op != 2'd1)
      for (int i = 0; i <= nr; i++) expq.push_back({1'b0, i == 0, i == nr, 4'(i)});
    if (v.op != 2'd0)
      for (int i = nr; i >= 0; i--) expq.push_back({1'b1, i == nr, i == 0, 4'(i)});

    ksel = v.ksel; op = v.op; din = v.din; corrupt = v.corrupt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ksel = 2'($urandom); op = 2'($urandom); din = {4{$urandom}};
    chk("busy_on_accept", 128'(busy), 128'd1);

    n = 0; rstalls = 0; stall_left = v.stall_len; got_done = 1'b0;
    while (n < 400 && !got_done) begin
      rnd_ack = 1'b1;
      if (rnd_req && !rnd_dec && int'(rnd_idx) == v.stall_idx && stall_left > 0) begin
        rnd_ack = 1'b0;
        stall_left--;
      end else if (rnd_stall && rnd_req && $urandom_range(0, 3) == 0) begin
        rnd_ack = 1'b0;
        rstalls++;
      end
      hold_chk = rnd_req && !rnd_ack;
      h_idx = rnd_idx;
      h_st  = rnd_st;
      if (rnd_req && rnd_ack) gotq.push_back({rnd_dec, rnd_first, rnd_last, rnd_idx});
      start = v.poke && (n == 3);
      if (start) din = ~v.din;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (hold_chk) begin
        chk("stall_hold_idx", 128'(rnd_idx), 128'(h_idx));
        chk("stall_hold_st", rnd_st, h_st);
      end
      got_done = done;
    end
    rnd_ack = 1'b1;

    chk("done_seen", 128'(got_done), 128'd1);
    chk("latency", 128'(n), 128'(v.exp_lat + rstalls));
    chk("dout", dout, m[127:0]);
    chk("pass", 128'(pass), 128'(v.exp_pass));
    chk("busy_at_done", 128'(busy), 128'd0);
    chk("trace_len", 128'(gotq.size()), 128'(expq.size()));
    mism = 0;
    for (int i = 0; i < gotq.size() && i < expq.size(); i++)
      if (gotq[i] !== expq[i]) mism++;
    chk("trace", 128'(mism), 128'd0);
`ifdef AES_SEQ_PERF_EN
    chk("perf_cycles", 128'(perf_cycles), 128'(n));
`endif
    @(posedge clk); #1;
    chk("done_pulse", 128'(done), 128'd0);
    chk("dout_hold", dout, m[127:0]);
  endtask

  task automatic err_case(input logic [1:0] k, input logic [1:0] o);
    logic [127:0] d0;
    d0 = dout;
    ksel = k; op = o; din = {4{$urandom}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", 128'(err), 128'd1);
    chk("err_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    chk("err_clear", 128'({err, busy, rnd_req}), 128'd0);
    chk("err_dout", dout, d0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [128:0] m;
    bit seen;
    int k;

    tab[0] = '{2'd0, 2'd0, 128'h00112233445566778899aabbccddeeff, -1, 0, 1'b0, 1'b0, 12, 1'b0};
    tab[1] = '{2'd2, 2'd1, 128'h8ea2b7ca516745bfeafc49904b496089, -1, 0, 1'b0, 1'b1, 16, 1'b0};
    tab[2] = '{2'd1, 2'd2, 128'h00112233445566778899aabbccddeeff, -1, 0, 1'b0, 1'b0, 27, 1'b1};
    tab[3] = '{2'd1, 2'd2, 128'h00112233445566778899aabbccddeeff, -1, 0, 1'b1, 1'b0, 27, 1'b0};
    tab[4] = '{2'd0, 2'd0, 128'h00112233445566778899aabbccddeeff,  5, 3, 1'b0, 1'b0, 15, 1'b0};
    tab[5] = '{2'd2, 2'd2, 128'hdeadbeef0123456789abcdeffedcba98, -1, 0, 1'b0, 1'b1, 31, 1'b1};

    rst_n = 1'b0; start = 1'b0; ksel = 2'd0; op = 2'd0; din = '0; rnd_ack = 1'b1; corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 128'({busy, done, pass, err, rnd_req, rnd_dec, rnd_first, rnd_last, rnd_idx}), 128'd0);
    chk("reset_dout", dout, 128'd0);
    chk("reset_st", rnd_st, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_op(tab[i], 1'b0);

    err_case(2'b11, 2'b00);
    err_case(2'b00, 2'b11);

    // Abort an encrypt at round 4
    ksel = 2'd0; op = 2'd0; din = tab[0].din; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (rnd_idx != 4'd4 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_r4", 128'(rnd_idx), 128'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 128'({busy, done, pass, err, rnd_req, rnd_dec, rnd_first, rnd_last, rnd_idx}), 128'd0);
    chk("abort_dout", dout, 128'd0);
    chk("abort_st", rnd_st, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    chk("no_done_after_abort", 128'(seen), 128'd0);
    run_op(tab[0], 1'b0);

    for (int i = 0; i < 20; i++) begin
      v.ksel      = 2'($urandom_range(0, 2));
      v.op        = 2'($urandom_range(0, 2));
      v.din       = {$urandom, $urandom, $urandom, $urandom};
      v.stall_idx = -1;
      v.stall_len = 0;
      v.corrupt   = 1'($urandom_range(0, 1));
      v.poke      = 1'($urandom_range(0, 1));
      v.exp_lat   = (v.op == 2'd2) ? 2 * nr_of(v.ksel) + 3 : nr_of(v.ksel) + 2;
      m           = model(v);
      v.exp_pass  = m[128];
      run_op(v, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
